// File: rtl/mic_frame_pairer.sv
// mic_frame_pairer: pairs I2S left/right words into stereo frames and buffers them in a FWFT FIFO.
// Ports: clk_in/rst_in (sync active-high reset); s_axis_tdata/tid/tvalid/tready word input
// (sample in tdata[27:4], tid 0 = left, 1 = right); m_left/m_right/m_valid/m_ready frame output;
// sync_err_cnt saturating pairing-error count; peak_clr/peak_left/peak_right per-channel |sample| peaks.
// Optional macro MIC_FRAME_PEAK_EN enables peak tracking; otherwise peaks read 0 and peak_clr is ignored.
module mic_frame_pairer #(
  parameter int FIFO_DEPTH = 8,
  parameter int SAMPLE_W = 24
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [31:0]         s_axis_tdata,
  input  logic [2:0]          s_axis_tid,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [SAMPLE_W-1:0] m_left,
  output logic [SAMPLE_W-1:0] m_right,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [7:0]          sync_err_cnt,
  input  logic                peak_clr,
  output logic [SAMPLE_W-2:0] peak_left,
  output logic [SAMPLE_W-2:0] peak_right
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {WAIT_L, WAIT_R} state_t;
  state_t state, state_n;
  logic [SAMPLE_W-1:0] sample, held;
  logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, empty, accept, is_l, is_r, push, pop, err;
  logic unused_ok;
  assign unused_ok = ^{s_axis_tdata, peak_clr};
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign s_axis_tready = !full && !rst_in;
  assign accept = s_axis_tvalid && s_axis_tready;
  assign sample = s_axis_tdata[SAMPLE_W+3:4];
  assign is_l = accept && s_axis_tid == 3'd0;
  assign is_r = accept && s_axis_tid == 3'd1;
  assign pop = !empty && m_ready;
  assign m_valid = !empty;
  // Head is gated so the outputs read 0 whenever no frame is held (including after reset).
  assign {m_left, m_right} = empty ? '0 : mem[rd_ptr];
  always_comb begin
    push = is_r && state == WAIT_R;
    err = (is_l && state == WAIT_R) || (is_r && state == WAIT_L);
    state_n = is_l ? WAIT_R : push ? WAIT_L : state;
  end
  always_ff @(posedge clk_in)
    if (rst_in) state <= WAIT_L;
    else state <= state_n;
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= {held, sample};
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      held <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      sync_err_cnt <= '0;
    end else begin
      if (is_l) held <= sample;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (err && sync_err_cnt != 8'hff) sync_err_cnt <= sync_err_cnt + 8'd1;
    end
  end
`ifdef MIC_FRAME_PEAK_EN
  // Negating the most negative value yields itself; its set MSB marks the case to saturate.
  function automatic logic [SAMPLE_W-2:0] mag(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] n;
    n = s[SAMPLE_W-1] ? -s : s;
    return n[SAMPLE_W-1] ? '1 : n[SAMPLE_W-2:0];
  endfunction
  logic [SAMPLE_W-2:0] mag_l, mag_r;
  assign mag_l = mag(held);
  assign mag_r = mag(sample);
  always_ff @(posedge clk_in) begin
    if (rst_in || peak_clr) begin
      peak_left <= '0;
      peak_right <= '0;
    end else if (push) begin
      if (mag_l > peak_left) peak_left <= mag_l;
      if (mag_r > peak_right) peak_right <= mag_r;
    end
  end
`else
  assign peak_left = '0;
  assign peak_right = '0;
`endif
endmodule

// File: tb/tb_mic_frame_pairer.sv
// tb_mic_frame_pairer: randomized scoreboard bench for mic_frame_pairer against a frame-level reference model.
module tb_mic_frame_pairer;
  localparam int DEPTH = 8;
  localparam int SW = 24;
  logic clk_in = 0, rst_in = 1;
  logic [31:0] s_axis_tdata = '0;
  logic [2:0] s_axis_tid = '0;
  logic s_axis_tvalid = 0, s_axis_tready;
  logic [SW-1:0] m_left, m_right;
  logic m_valid, m_ready = 0;
  logic [7:0] sync_err_cnt;
  logic peak_clr = 0;
  logic [SW-2:0] peak_left, peak_right;
  int checks = 0, failures = 0;
  logic [2*SW-1:0] exp_q[$];
  bit have_l = 0, post_rst = 0, done = 0;
  logic [SW-1:0] held_l;
  int m_err = 0, m_pk_l = 0, m_pk_r = 0;

  mic_frame_pairer #(.FIFO_DEPTH(DEPTH), .SAMPLE_W(SW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_axis_tdata(s_axis_tdata), .s_axis_tid(s_axis_tid),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_left(m_left), .m_right(m_right), .m_valid(m_valid), .m_ready(m_ready),
    .sync_err_cnt(sync_err_cnt), .peak_clr(peak_clr),
    .peak_left(peak_left), .peak_right(peak_right)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int absat(input logic [SW-1:0] s);
    int v;
    v = $signed(s);
    v = v < 0 ? -v : v;
    return v > (1 << (SW-1)) - 1 ? (1 << (SW-1)) - 1 : v;
  endfunction

  function automatic void bump_err();
    if (m_err < 255) m_err++;
  endfunction

  // Reference model: a right word completes a frame only if a left word is pending;
  // a left word arriving while one is pending replaces it and counts as an error.
  function automatic void model_word(input logic [2:0] t, input logic [SW-1:0] s);
    if (t == 0) begin
      if (have_l) bump_err();
      held_l = s;
      have_l = 1;
    end else if (t == 1) begin
      if (have_l) begin
        exp_q.push_back({held_l, s});
        have_l = 0;
`ifdef MIC_FRAME_PEAK_EN
        if (absat(held_l) > m_pk_l) m_pk_l = absat(held_l);
        if (absat(s) > m_pk_r) m_pk_r = absat(s);
`endif
      end else bump_err();
    end
  endfunction

  always @(negedge clk_in) begin
    if (rst_in) begin
      check("tready_in_reset", s_axis_tready, 0);
      exp_q.delete();
      have_l = 0;
      m_err = 0;
      m_pk_l = 0;
      m_pk_r = 0;
      post_rst = 1;
    end else begin
      bit room;
      room = exp_q.size() < DEPTH;
      if (post_rst) begin
        check("reset_m_left", m_left, 0);
        check("reset_m_right", m_right, 0);
        post_rst = 0;
      end
      check("tready", s_axis_tready, room);
      check("m_valid", m_valid, exp_q.size() != 0);
      check("sync_err_cnt", sync_err_cnt, m_err);
      check("peak_left", peak_left, m_pk_l);
      check("peak_right", peak_right, m_pk_r);
      if (exp_q.size() != 0 && m_ready) check("frame", {m_left, m_right}, exp_q.pop_front());
      if (s_axis_tvalid && room) model_word(s_axis_tid, s_axis_tdata[27:4]);
`ifdef MIC_FRAME_PEAK_EN
      if (peak_clr) begin
        m_pk_l = 0;
        m_pk_r = 0;
      end
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [2:0] t, input logic [SW-1:0] s);
    int n = 0;
    bit acc = 0;
    s_axis_tid = t;
    s_axis_tdata = {4'($urandom), s, 4'($urandom)};
    s_axis_tvalid = 1;
    while (!acc) begin
      @(negedge clk_in);
      acc = s_axis_tready;
      @(posedge clk_in);
      #1;
      n++;
      if (!acc && n > 500) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: word tid=%0d not accepted within %0d cycles", t, n);
        break;
      end
    end
    s_axis_tvalid = 0;
  endtask

  task automatic do_reset();
    rst_in = 1;
    tick(2);
    rst_in = 0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    tick(3);
    rst_in = 0;
    m_ready = 1;
    send(0, 24'h000123);
    send(1, 24'h000456);
    tick(3);
    send(1, 24'd5);
    send(0, 24'd6);
    send(1, 24'd7);
    tick(2);
    send(0, 24'd1);
    send(0, 24'd2);
    send(1, 24'd3);
    tick(2);
    m_ready = 0;
    fork
      for (int i = 1; i <= 9; i++) begin
        send(0, SW'(i));
        send(1, SW'(i + 100));
      end
      begin
        tick(60);
        m_ready = 1;
      end
    join
    tick(4);
    send(0, 24'd5);
    do_reset();
    send(1, 24'd7);
    tick(3);
    send(0, 24'd100);
    send(1, 24'd10);
    send(0, 24'h800000);
    send(1, 24'h7fff00);
    send(0, 24'd50);
    send(1, 24'hfffff0);
    tick(2);
    peak_clr = 1;
    tick(1);
    peak_clr = 0;
    tick(2);
    for (int i = 0; i < 300; i++) send(1, SW'($urandom));
    tick(2);
    do_reset();
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          logic [2:0] t;
          logic [SW-1:0] s;
          n = $urandom_range(0, 19);
          t = n < 9 ? 3'd0 : n < 18 ? 3'd1 : 3'($urandom_range(2, 7));
          n = $urandom_range(0, 15);
          s = n == 0 ? 24'h800000 : n == 1 ? 24'h7fffff : SW'($urandom);
          send(t, s);
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
        done = 1;
      end
      while (!done) begin
        tick(1);
        m_ready = $urandom_range(0, 3) != 0;
        peak_clr = $urandom_range(0, 31) == 0;
      end
    join
    m_ready = 1;
    peak_clr = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    tick(2);
    check("drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
